// File: rtl/gshare_bp_pkg.sv
// Shared types and helpers for the gshare branch predictor.
// Latency: none. These are pure types and functions.
// Backpressure: not applicable.
//
// Contents:
//   bp_state_e     predictor FSM state (sweep init / normal operation)
//   pht_op_e       operation applied by the PHT write port
//   bp_wnt         weakly-not-taken init value for a CNT_W-bit counter
//   sat_inc/dec    saturating counter step for a CNT_W-bit counter
//   bp_hash        gshare index: PC slice XOR zero-extended history
package gshare_bp_pkg;

  typedef enum logic {
    BP_INIT  = 1'b0,
    BP_READY = 1'b1
  } bp_state_e;

  typedef enum logic [1:0] {
    PHT_OP_INIT = 2'd0,
    PHT_OP_INC  = 2'd1,
    PHT_OP_DEC  = 2'd2
  } pht_op_e;

  // Weakly-not-taken value for the default 2-bit counter.
  localparam logic [1:0] BP_WNT_DEFAULT = 2'b01;

  // All-ones mask of n bits, clamped to the 32-bit helper width.
  function automatic logic [31:0] bp_mask(input int n);
    if (n >= 32) return '1;
    return (32'd1 << n) - 32'd1;
  endfunction

  // Weakly-not-taken: MSB clear, every lower bit set.
  function automatic logic [31:0] bp_wnt(input int cnt_w);
    return (32'd1 << (cnt_w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int cnt_w);
    if (v >= bp_mask(cnt_w)) return bp_mask(cnt_w);
    return v + 32'd1;
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] v, input int cnt_w);
    if (v == 32'd0) return 32'd0;
    return v - 32'd1;
  endfunction

  // idx = pc[pc_lsb +: idx_w] ^ zero_extend(ghr[ghr_w-1:0]).
  function automatic logic [31:0] bp_hash(input logic [63:0] pc, input logic [31:0] ghr,
                                          input int pc_lsb, input int idx_w, input int ghr_w);
    return (32'(pc >> pc_lsb) & bp_mask(idx_w)) ^ (ghr & bp_mask(ghr_w));
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: 2**IDX_W saturating counters with one read and one RMW write port.
// Latency: read data is the current array contents; the parent registers it at the edge.
// Backpressure: none; a write is applied at every clock edge where wr_en is high.
//
// Ports:
//   clk      clock
//   rd_idx   lookup index
//   rd_dir   direction bit (counter MSB) of PHT[rd_idx] before this cycle's write
//   wr_en    apply wr_op to PHT[wr_idx] at the end of this cycle
//   wr_op    PHT_OP_INIT (load weakly-not-taken), PHT_OP_INC, PHT_OP_DEC (saturating)
//   wr_idx   write index
module bp_pht
  import gshare_bp_pkg::*;
#(
  parameter int IDX_W = 8,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_dir,
  input  logic             wr_en,
  input  pht_op_e          wr_op,
  input  logic [IDX_W-1:0] wr_idx
);

  localparam int DEPTH = 2 ** IDX_W;

  // No reset on the array: the parent's init sweep loads every entry.
  logic [CNT_W-1:0] mem [DEPTH];

  // The parent samples rd_dir into its output registers at the same edge that
  // commits any write, so a same-cycle lookup always observes the old counter.
  assign rd_dir = mem[rd_idx][CNT_W-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      case (wr_op)
        PHT_OP_INIT: mem[wr_idx] <= CNT_W'(bp_wnt(CNT_W));
        PHT_OP_INC:  mem[wr_idx] <= CNT_W'(sat_inc(32'(mem[wr_idx]), CNT_W));
        PHT_OP_DEC:  mem[wr_idx] <= CNT_W'(sat_dec(32'(mem[wr_idx]), CNT_W));
        default:     mem[wr_idx] <= mem[wr_idx];
      endcase
    end
  end

endmodule

// File: rtl/gshare_bp_param.sv
// Parametrised gshare conditional-branch predictor with speculative global history.
// Latency: prediction 1 cycle after accept; PHT init sweep takes 2**IDX_W cycles after reset.
// Backpressure: pred_ready low during init sweep and in any cycle carrying a mispredict update.
//
// Optional feature macro: BP_STATS_EN adds stat_lookups / stat_mispred counters and ports.
//
// Ports:
//   clk, rst_n                      clock; synchronous active-low reset
//   pred_req/pred_pc/pred_uncond    lookup request (accepted when pred_req && pred_ready)
//   pred_ready                      lookup can be accepted this cycle
//   pred_valid/pred_taken/pred_ghr  registered result and history snapshot for the branch
//   upd_valid/upd_pc/upd_ghr        resolved conditional branch with its snapshot
//   upd_taken/upd_mispred           actual outcome; wrong-prediction flag
//   stat_lookups/stat_mispred       (BP_STATS_EN only) saturating event counters
module gshare_bp_param
  import gshare_bp_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int PC_LSB = 2,
  parameter int IDX_W  = 8,
  parameter int GHR_W  = 8,
  parameter int CNT_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_req,
  input  logic [PC_W-1:0]  pred_pc,
  input  logic             pred_uncond,
  output logic             pred_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic [GHR_W-1:0] upd_ghr,
  input  logic             upd_taken,
  input  logic             upd_mispred
`ifdef BP_STATS_EN
  ,
  output logic [31:0]      stat_lookups,
  output logic [31:0]      stat_mispred
`endif
);

  // Elaboration-time parameter sanity.
  generate
    if (GHR_W < 1 || GHR_W > IDX_W) begin : g_bad_ghr_w
      $error("gshare_bp_param: GHR_W must be in 1..IDX_W");
    end
    if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
      $error("gshare_bp_param: CNT_W must be in 2..32");
    end
    if (PC_W > 64 || PC_LSB + IDX_W > PC_W) begin : g_bad_pc_w
      $error("gshare_bp_param: PC slice out of range");
    end
  endgenerate

  localparam logic [IDX_W-1:0] SWEEP_LAST = '1;

  bp_state_e        state;
  logic [IDX_W-1:0] sweep_idx;
  logic [GHR_W-1:0] ghr;

  logic             is_ready;
  logic             mispred_fix;
  logic             lk_acc;
  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  logic             pht_rd_dir;
  logic             pht_wr_en;
  pht_op_e          pht_wr_op;
  logic [IDX_W-1:0] pht_wr_idx;
  logic [GHR_W-1:0] ghr_spec_nxt;
  logic [GHR_W-1:0] ghr_fix_nxt;

  assign is_ready    = (state == BP_READY);
  assign mispred_fix = upd_valid && upd_mispred;

  // A mispredict rewrites history this cycle, so a lookup would hash a stale GHR.
  assign pred_ready  = is_ready && !mispred_fix;
  assign lk_acc      = pred_req && pred_ready;

  assign lk_idx = IDX_W'(bp_hash(64'(pred_pc), 32'(ghr),     PC_LSB, IDX_W, GHR_W));
  assign up_idx = IDX_W'(bp_hash(64'(upd_pc),  32'(upd_ghr), PC_LSB, IDX_W, GHR_W));

  // Next history values: speculative shift of the predicted direction, or
  // recovery from the mispredicted branch's own snapshot plus its real outcome.
  generate
    if (GHR_W == 1) begin : g_ghr_one
      assign ghr_spec_nxt = pht_rd_dir;
      assign ghr_fix_nxt  = upd_taken;
    end else begin : g_ghr_shift
      assign ghr_spec_nxt = {ghr[GHR_W-2:0], pht_rd_dir};
      assign ghr_fix_nxt  = {upd_ghr[GHR_W-2:0], upd_taken};
    end
  endgenerate

  // Single PHT write port: owned by the init sweep, then by resolved updates.
  always_comb begin
    pht_wr_en  = 1'b0;
    pht_wr_op  = PHT_OP_INIT;
    pht_wr_idx = sweep_idx;
    if (rst_n) begin
      if (!is_ready) begin
        pht_wr_en = 1'b1;
      end else if (upd_valid) begin
        pht_wr_en  = 1'b1;
        pht_wr_op  = upd_taken ? PHT_OP_INC : PHT_OP_DEC;
        pht_wr_idx = up_idx;
      end
    end
  end

  bp_pht #(
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_pht (
    .clk    (clk),
    .rd_idx (lk_idx),
    .rd_dir (pht_rd_dir),
    .wr_en  (pht_wr_en),
    .wr_op  (pht_wr_op),
    .wr_idx (pht_wr_idx)
  );

  // Control FSM, history register and registered lookup outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= BP_INIT;
      sweep_idx  <= '0;
      ghr        <= '0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_ghr   <= '0;
    end else begin
      pred_valid <= lk_acc;
      if (lk_acc) begin
        pred_taken <= pred_uncond | pht_rd_dir;
        pred_ghr   <= ghr;
      end
      case (state)
        BP_INIT: begin
          sweep_idx <= sweep_idx + 1'b1;
          if (sweep_idx == SWEEP_LAST) begin
            state <= BP_READY;
          end
        end
        BP_READY: begin
          // Recovery wins; pred_ready is low then, so no lookup competes anyway.
          if (mispred_fix) begin
            ghr <= ghr_fix_nxt;
          end else if (lk_acc && !pred_uncond) begin
            ghr <= ghr_spec_nxt;
          end
        end
        default: state <= BP_INIT;
      endcase
    end
  end

`ifdef BP_STATS_EN
  // Event counters; they stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_lookups <= '0;
      stat_mispred <= '0;
    end else begin
      if (lk_acc && !pred_uncond && stat_lookups != 32'hFFFF_FFFF) begin
        stat_lookups <= stat_lookups + 32'd1;
      end
      if (is_ready && mispred_fix && stat_mispred != 32'hFFFF_FFFF) begin
        stat_mispred <= stat_mispred + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gshare_bp_param.sv
// Directed bench for gshare_bp_param with default parameters.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
module tb_gshare_bp_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pred_req;
  logic [31:0] pred_pc;
  logic        pred_uncond;
  logic        pred_ready;
  logic        pred_valid;
  logic        pred_taken;
  logic [7:0]  pred_ghr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [7:0]  upd_ghr;
  logic        upd_taken;
  logic        upd_mispred;
`ifdef BP_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispred;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  gshare_bp_param dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pred_req    (pred_req),
    .pred_pc     (pred_pc),
    .pred_uncond (pred_uncond),
    .pred_ready  (pred_ready),
    .pred_valid  (pred_valid),
    .pred_taken  (pred_taken),
    .pred_ghr    (pred_ghr),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_ghr     (upd_ghr),
    .upd_taken   (upd_taken),
    .upd_mispred (upd_mispred)
`ifdef BP_STATS_EN
    ,
    .stat_lookups(stat_lookups),
    .stat_mispred(stat_mispred)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_req    = 1'b0;
    pred_pc     = '0;
    pred_uncond = 1'b0;
    upd_valid   = 1'b0;
    upd_pc      = '0;
    upd_ghr     = '0;
    upd_taken   = 1'b0;
    upd_mispred = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic uncond);
    pred_req    = 1'b1;
    pred_pc     = pc;
    pred_uncond = uncond;
    step();
    idle();
  endtask

  task automatic update(input logic [31:0] pc, input logic [7:0] g,
                        input logic taken, input logic mis);
    upd_valid   = 1'b1;
    upd_pc      = pc;
    upd_ghr     = g;
    upd_taken   = taken;
    upd_mispred = mis;
    step();
    idle();
  endtask

  // Counts edges until pred_ready; returns the bound value if it never rises.
  task automatic wait_ready(output int n);
    n = 0;
    while (!pred_ready && n < 400) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    idle();
    rst_n = 1'b0;
    step();
    step();
    tests_run++;
    if (pred_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", pred_valid); end
    tests_run++;
    if (pred_taken !== 1'b0) begin tests_failed++; $display("FAIL reset_taken: got %b want 0", pred_taken); end
    tests_run++;
    if (pred_ghr !== 8'h00) begin tests_failed++; $display("FAIL reset_ghr: got %h want 00", pred_ghr); end
    tests_run++;
    if (pred_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b want 0", pred_ready); end
    rst_n = 1'b1;
    wait_ready(n);
    tests_run++;
    if (n != 256) begin tests_failed++; $display("FAIL init_cycles: got %0d want 256", n); end
  endtask

  task automatic test_lookup_basic();
    lookup(32'h100, 1'b0);
    tests_run++;
    if (pred_valid !== 1'b1) begin tests_failed++; $display("FAIL lk_valid: got %b want 1", pred_valid); end
    tests_run++;
    if (pred_taken !== 1'b0) begin tests_failed++; $display("FAIL lk_taken: got %b want 0", pred_taken); end
    tests_run++;
    if (pred_ghr !== 8'h00) begin tests_failed++; $display("FAIL lk_ghr: got %h want 00", pred_ghr); end
    step();
    tests_run++;
    if (pred_valid !== 1'b0) begin tests_failed++; $display("FAIL lk_valid_drop: got %b want 0", pred_valid); end
  endtask

  // PHT[0x10] 01 -> 10 -> 11 -> 11, then a lookup with GHR=0 predicts taken.
  task automatic test_update_inc();
    for (int i = 0; i < 3; i++) update(32'h40, 8'h00, 1'b1, 1'b0);
    lookup(32'h40, 1'b0);
    tests_run++;
    if (pred_taken !== 1'b1) begin tests_failed++; $display("FAIL inc_taken: got %b want 1", pred_taken); end
    tests_run++;
    if (pred_ghr !== 8'h00) begin tests_failed++; $display("FAIL inc_ghr: got %h want 00", pred_ghr); end
  endtask

  task automatic test_back_to_back();
    // Recover GHR to 0; this also takes PHT[0x80] from 01 to 00.
    update(32'h200, 8'h00, 1'b0, 1'b1);
    pred_req = 1'b1;
    pred_pc  = 32'h40;
    step();
    tests_run++;
    if (pred_taken !== 1'b1 || pred_ghr !== 8'h00)
      begin tests_failed++; $display("FAIL b2b_first: got t=%b g=%h want t=1 g=00", pred_taken, pred_ghr); end
    pred_pc = 32'h44;  // idx 0x11 ^ 0x01 = 0x10 (counter 11)
    step();
    tests_run++;
    if (pred_taken !== 1'b1 || pred_ghr !== 8'h01)
      begin tests_failed++; $display("FAIL b2b_second: got t=%b g=%h want t=1 g=01", pred_taken, pred_ghr); end
    pred_pc = 32'h0;   // idx 0x03, weakly not taken
    step();
    tests_run++;
    if (pred_taken !== 1'b0 || pred_ghr !== 8'h03)
      begin tests_failed++; $display("FAIL b2b_third: got t=%b g=%h want t=0 g=03", pred_taken, pred_ghr); end
    idle();
    step();
    tests_run++;
    if (pred_valid !== 1'b0 || pred_ghr !== 8'h03)
      begin tests_failed++; $display("FAIL b2b_hold: got v=%b g=%h want v=0 g=03", pred_valid, pred_ghr); end
  endtask

  task automatic test_mispredict();
    update(32'h300, 8'h52, 1'b1, 1'b1);  // GHR <= A5
    pred_req    = 1'b1;
    pred_pc     = 32'h0;
    upd_valid   = 1'b1;
    upd_pc      = 32'h400;
    upd_ghr     = 8'h0F;
    upd_taken   = 1'b0;
    upd_mispred = 1'b1;
    #1;
    tests_run++;
    if (pred_ready !== 1'b0) begin tests_failed++; $display("FAIL mis_ready: got %b want 0", pred_ready); end
    step();
    idle();
    tests_run++;
    if (pred_valid !== 1'b0) begin tests_failed++; $display("FAIL mis_noaccept: got %b want 0", pred_valid); end
    lookup(32'h0, 1'b0);
    tests_run++;
    if (pred_ghr !== 8'h1E) begin tests_failed++; $display("FAIL mis_ghr: got %h want 1E", pred_ghr); end
  endtask

  // PHT[0x80] is 00; a wrapping counter would turn MSB on after the first decrement.
  task automatic test_sat_dec();
    update(32'h500, 8'h00, 1'b0, 1'b1);  // GHR <= 0
    for (int i = 0; i < 4; i++) begin
      update(32'h200, 8'h00, 1'b0, 1'b0);
      lookup(32'h200, 1'b0);
      tests_run++;
      if (pred_taken !== 1'b0 || pred_ghr !== 8'h00)
        begin tests_failed++; $display("FAIL sat_dec%0d: got t=%b g=%h want t=0 g=00", i, pred_taken, pred_ghr); end
    end
  endtask

  // Same-cycle lookup and decrement of PHT[0x10] (10): lookup must see 10.
  task automatic test_rbw();
    update(32'h40, 8'h00, 1'b0, 1'b0);   // 11 -> 10
    pred_req  = 1'b1;
    pred_pc   = 32'h40;
    upd_valid = 1'b1;
    upd_pc    = 32'h40;
    upd_ghr   = 8'h00;
    upd_taken = 1'b0;
    step();
    idle();
    tests_run++;
    if (pred_taken !== 1'b1) begin tests_failed++; $display("FAIL rbw_old: got %b want 1", pred_taken); end
    lookup(32'h44, 1'b0);  // GHR=01 -> idx 0x10, now 01
    tests_run++;
    if (pred_taken !== 1'b0 || pred_ghr !== 8'h01)
      begin tests_failed++; $display("FAIL rbw_new: got t=%b g=%h want t=0 g=01", pred_taken, pred_ghr); end
  endtask

  task automatic test_uncond();
    lookup(32'h200, 1'b1);
    tests_run++;
    if (pred_taken !== 1'b1 || pred_ghr !== 8'h02)
      begin tests_failed++; $display("FAIL unc_taken: got t=%b g=%h want t=1 g=02", pred_taken, pred_ghr); end
    lookup(32'h0, 1'b0);
    tests_run++;
    if (pred_ghr !== 8'h02) begin tests_failed++; $display("FAIL unc_ghr: got %h want 02", pred_ghr); end
  endtask

  task automatic test_mid_sweep_reset();
    int n;
    lookup(32'h0, 1'b1);  // leaves pred_taken=1, pred_ghr=04
    rst_n = 1'b0;
    step();
    tests_run++;
    if (pred_taken !== 1'b0 || pred_ghr !== 8'h00 || pred_valid !== 1'b0)
      begin tests_failed++; $display("FAIL rst_outs: got t=%b g=%h v=%b want 0", pred_taken, pred_ghr, pred_valid); end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) step();
    tests_run++;
    if (pred_ready !== 1'b0) begin tests_failed++; $display("FAIL sweep_ready: got %b want 0", pred_ready); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wait_ready(n);
    tests_run++;
    if (n != 256) begin tests_failed++; $display("FAIL resweep_cycles: got %0d want 256", n); end
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats();
    tests_run++;
    if (stat_lookups !== 32'd0 || stat_mispred !== 32'd0)
      begin tests_failed++; $display("FAIL stat_reset: got %0d/%0d want 0/0", stat_lookups, stat_mispred); end
    for (int i = 0; i < 5; i++) lookup(32'h100 + 32'(i * 4), 1'b0);
    lookup(32'h80, 1'b1);
    update(32'h100, 8'h00, 1'b1, 1'b0);
    update(32'h100, 8'h00, 1'b1, 1'b1);
    update(32'h104, 8'h00, 1'b0, 1'b1);
    tests_run++;
    if (stat_lookups !== 32'd5) begin tests_failed++; $display("FAIL stat_lookups: got %0d want 5", stat_lookups); end
    tests_run++;
    if (stat_mispred !== 32'd2) begin tests_failed++; $display("FAIL stat_mispred: got %0d want 2", stat_mispred); end
  endtask
`endif

  initial begin
    test_reset();
    test_lookup_basic();
    test_update_inc();
    test_back_to_back();
    test_mispredict();
    test_sat_dec();
    test_rbw();
    test_uncond();
    test_mid_sweep_reset();
`ifdef BP_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
